// File: rtl/rom_ctrl_pkg.sv
// Shared types for the boot-ROM access arbiter: response-slot states and requester ids.
package rom_ctrl_pkg;

  typedef enum logic [1:0] {
    EMPTY,
    PEND,
    HOLD
  } slot_state_e;

  typedef enum logic {
    PORT_I,
    PORT_D
  } port_id_e;

endpackage

// File: rtl/rom_rr_arb2.sv
// Two-input round-robin arbiter; the pointer remembers the last winner and moves only on a grant.
module rom_rr_arb2
  import rom_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       en,
  output logic [1:0] gnt,
  output port_id_e   winner
);

  port_id_e last;

  always_comb begin
    gnt    = '0;
    winner = PORT_I;
    if (req[0] && req[1]) begin
      winner = (last == PORT_I) ? PORT_D : PORT_I;
    end else if (req[1]) begin
      winner = PORT_D;
    end
    if (en && (|req)) begin
      gnt = (winner == PORT_D) ? 2'b10 : 2'b01;
    end
  end

  // Reset value PORT_D makes I win the first contested cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last <= PORT_D;
    end else if (|gnt) begin
      last <= winner;
    end
  end

endmodule

// File: rtl/rom_ctrl_arbiter.sv
// Shares one synchronous-read ROM between instruction-fetch and data-load ports with a single
// response slot that buffers read data while the owning requester back-pressures.
module rom_ctrl_arbiter
  import rom_ctrl_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              i_req_i,
  input  logic [ADDR_W-1:0] i_addr_i,
  input  logic              i_we_i,
  output logic              i_gnt_o,
  output logic              i_rvalid_o,
  output logic [WIDTH-1:0]  i_rdata_o,
  output logic              i_err_o,
  input  logic              i_rready_i,
  input  logic              d_req_i,
  input  logic [ADDR_W-1:0] d_addr_i,
  input  logic              d_we_i,
  output logic              d_gnt_o,
  output logic              d_rvalid_o,
  output logic [WIDTH-1:0]  d_rdata_o,
  output logic              d_err_o,
  input  logic              d_rready_i,
  output logic              rom_req_o,
  output logic [DEPTH-1:0]  rom_addr_o,
  input  logic [WIDTH-1:0]  rom_rdata_i
);

  slot_state_e state, state_next;
  port_id_e    owner, owner_next;
  logic        err, err_next;
  logic [WIDTH-1:0] hold_data, hold_data_next;

  logic              resp_valid;
  logic              owner_rready;
  logic              slot_free;
  logic [1:0]        gnt;
  port_id_e          winner;
  logic              granted;
  logic [ADDR_W-1:0] win_addr;
  logic              win_we;
  logic              legal;
  logic [WIDTH-1:0]  resp_data;
  logic              unused_addr_bits;

  assign resp_valid   = (state != EMPTY);
  assign owner_rready = (owner == PORT_I) ? i_rready_i : d_rready_i;
  // The slot may be refilled in the same cycle the owner takes its response.
  assign slot_free    = (state == EMPTY) || owner_rready;

  rom_rr_arb2 u_arb (
    .clk    (clk_i),
    .rst    (rst_i),
    .req    ({d_req_i, i_req_i}),
    .en     (slot_free && !rst_i),
    .gnt    (gnt),
    .winner (winner)
  );

  assign granted  = |gnt;
  assign i_gnt_o  = gnt[0];
  assign d_gnt_o  = gnt[1];
  assign win_addr = (winner == PORT_D) ? d_addr_i : i_addr_i;
  assign win_we   = (winner == PORT_D) ? d_we_i   : i_we_i;
  assign legal    = !win_we && (win_addr[ADDR_W-1:DEPTH+2] == '0);

  assign unused_addr_bits = ^win_addr[1:0];

  assign rom_req_o  = granted && legal;
  assign rom_addr_o = rom_req_o ? win_addr[DEPTH+1:2] : '0;

  always_comb begin
    resp_data = '0;
    case (state)
      PEND:    resp_data = err ? '0 : rom_rdata_i;
      HOLD:    resp_data = hold_data;
      default: resp_data = '0;
    endcase
  end

  assign i_rvalid_o = resp_valid && (owner == PORT_I);
  assign d_rvalid_o = resp_valid && (owner == PORT_D);
  assign i_rdata_o  = i_rvalid_o ? resp_data : '0;
  assign d_rdata_o  = d_rvalid_o ? resp_data : '0;
  assign i_err_o    = i_rvalid_o && err;
  assign d_err_o    = d_rvalid_o && err;

  always_comb begin
    state_next     = state;
    owner_next     = owner;
    err_next       = err;
    hold_data_next = hold_data;
    if (granted) begin
      state_next = PEND;
      owner_next = winner;
      err_next   = !legal;
    end else begin
      case (state)
        PEND: begin
          if (owner_rready) begin
            state_next = EMPTY;
          end else begin
            state_next     = HOLD;
            hold_data_next = err ? '0 : rom_rdata_i;
          end
        end
        HOLD: begin
          if (owner_rready) begin
            state_next = EMPTY;
          end
        end
        default: state_next = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state     <= EMPTY;
      owner     <= PORT_I;
      err       <= 1'b0;
      hold_data <= '0;
    end else begin
      state     <= state_next;
      owner     <= owner_next;
      err       <= err_next;
      hold_data <= hold_data_next;
    end
  end

endmodule

// File: doc/rom_ctrl_arbiter.md
Name: rom_ctrl_arbiter

Overview:
- Shares one single-port, synchronous-read ROM macro (1-cycle read latency, word-addressed, read-enable gated) between two requesters: instruction fetch (port I) and data load (port D).
- Handles:
  - req/gnt handshake on each port;
  - round-robin arbitration;
  - byte-to-word address translation and range checking;
  - write rejection;
  - response buffering when a requester back-pressures.
- Sits between the core's memory ports and the boot ROM instance.

Parameters:
- WIDTH, 32, ROM word width in bits (also the rdata width).
- DEPTH, 8, ROM word-address width; ROM holds 2**DEPTH words.
- ADDR_W, 32, requester byte-address width.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  reset, asynchronous, active-high.
- i_req_i  in  1  port I request.
- i_addr_i  in  ADDR_W  port I byte address.
- i_we_i  in  1  port I write request (always illegal).
- i_gnt_o  out  1  port I request accepted this cycle.
- i_rvalid_o  out  1  port I response valid.
- i_rdata_o  out  WIDTH  port I read data.
- i_err_o  out  1  port I error, qualified by i_rvalid_o.
- i_rready_i  in  1  port I accepts the response.
- d_req_i, d_addr_i, d_we_i, d_gnt_o, d_rvalid_o, d_rdata_o, d_err_o, d_rready_i: same as port I, for port D.
- rom_req_o  out  1  ROM read enable.
- rom_addr_o  out  DEPTH  ROM word address.
- rom_rdata_i  in  WIDTH  ROM read data, valid the cycle after rom_req_o.

Behaviour:
- Reset, asynchronous:
  - all gnt/rvalid/err/rom_req outputs go to 0; rdata outputs and rom_addr_o go to 0;
  - response slot empty; round-robin pointer favours I.
- Address mapping:
  - word index = addr[DEPTH+1:2];
  - request is legal iff we=0 and addr[ADDR_W-1:DEPTH+2]==0;
  - addr[1:0] is ignored (no alignment error).
- Slot states: EMPTY, PEND (ROM read in flight, owner+err latched), HOLD (data captured, waiting on rready).
- Grant rules:
  - gnt is combinational and asserted for at most one port per cycle;
  - grant is allowed when the slot is EMPTY, or when it will free this cycle (owner's rvalid & rready both high);
  - no grant while HOLD persists or PEND is not accepted.
- Arbitration:
  - a single requester wins;
  - if both request, the port not granted last wins;
  - the pointer updates only on a grant.
- Legal grant at cycle t:
  - rom_req_o=1 and rom_addr_o=word index at cycle t (combinational);
  - slot becomes PEND.
- Illegal grant at cycle t:
  - rom_req_o=0;
  - slot becomes PEND with err=1.
- Cycle t+1 (PEND):
  - owner rvalid_o=1;
  - rdata_o = rom_rdata_i, or 0 if err;
  - err_o = err.
  - If owner rready=1: slot frees (or refills on a new grant).
  - Else: rdata/err are latched into the hold register and the slot goes to HOLD.
- HOLD:
  - rvalid_o stays 1 with stable rdata/err until rready=1, then the slot goes to EMPTY (or PEND on a same-cycle grant).
- Back-to-back throughput: one access per cycle when rready is held high.
- The non-owner port's rvalid_o is always 0; rdata_o is 0 when rvalid_o=0.
- Requests held with gnt=0 must keep addr/we stable; the block does not latch un-granted requests.
- Reset mid-transaction: the in-flight response is dropped; no rvalid after reset release until a new grant.

Decomposition:
- Package rom_ctrl_pkg:
  - slot_state_e enum (EMPTY, PEND, HOLD);
  - port_id_e enum (PORT_I, PORT_D).
- One sub-module, rom_rr_arb2: 2-input round-robin arbiter with last-grant pointer, update-enable, and asynchronous active-high reset.
- The ROM instance stays outside this block.

Test Plan:
1. Reset, then a single I read at addr 0x0000_0010 with rready=1 → rom_addr_o=4 at t, i_rvalid_o=1 at t+1 with data=mem[4], err=0.
2. I and D request simultaneously and continuously, rready=1 → grants alternate I,D,I,D starting with I after reset; one rvalid per cycle.
3. D write at 0x4 or D read at 0x0000_0400 (DEPTH=8) → d_gnt_o=1, rom_req_o=0, d_rvalid_o=1 with err=1 and rdata=0 next cycle.
4. I read granted, i_rready_i held 0 for 3 cycles → rvalid and data stable over 4 cycles; no grants to D meanwhile; D is granted the cycle rready rises.
5. Assert rst_i while the slot is PEND → all outputs 0 immediately; no spurious rvalid after release.
6. Back-to-back I reads to words 0..7 with rready=1 → 8 responses in 8 consecutive cycles, in order, with correct data.
